// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX types: forwarding select codes, stage FSM states and the registered control bundle.
// Pure type/constant package, no logic.
package id_ex_stage_pkg;

    localparam int CTRL_ALU_OP_W = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } idex_state_e;

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     alu_src_imm;
        logic [CTRL_ALU_OP_W-1:0] alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields in, EX register view and operands out.
// master drives ID/forwarding inputs, slave is the pipeline stage.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_OP_W   = 4
);
    logic                  id_valid;
    logic [31:0]           id_pc;
    logic [31:0]           id_instr;
    logic [4:0]            id_rs1_addr;
    logic [4:0]            id_rs2_addr;
    logic [4:0]            id_rd_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_alu_src_imm;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic                  ex_ready;
    logic                  flush;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic [DATA_WIDTH-1:0] mem_fwd_data;
    logic [DATA_WIDTH-1:0] wb_fwd_data;

    logic                  id_stall;
    logic                  ex_valid;
    logic [31:0]           ex_pc;
    logic [31:0]           ex_instr;
    logic [4:0]            ex_rs1_addr;
    logic [4:0]            ex_rs2_addr;
    logic [4:0]            ex_rd_addr;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic [DATA_WIDTH-1:0] ex_op_a;
    logic [DATA_WIDTH-1:0] ex_op_b;
    logic [DATA_WIDTH-1:0] ex_store_data;

    modport master (
        output id_valid, id_pc, id_instr, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_alu_src_imm, id_alu_op,
               ex_ready, flush, forward_a, forward_b, mem_fwd_data, wb_fwd_data,
        input  id_stall, ex_valid, ex_pc, ex_instr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op,
               ex_op_a, ex_op_b, ex_store_data
    );

    modport slave (
        input  id_valid, id_pc, id_instr, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_uses_rs1, id_uses_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_alu_src_imm, id_alu_op,
               ex_ready, flush, forward_a, forward_b, mem_fwd_data, wb_fwd_data,
        output id_stall, ex_valid, ex_pc, ex_instr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op,
               ex_op_a, ex_op_b, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Operand forwarding select: regfile, MEM or WB value; reserved code 11 falls back to regfile.
// Purely combinational, no backpressure.
module operand_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            fwd,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] operand
);
    always_comb begin
        operand = reg_data;
        case (fwd)
            FWD_MEM: operand = mem_data;
            FWD_WB:  operand = wb_data;
            default: operand = reg_data;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use bubble, flush and EX-stall operand capture; ID->EX in 1 cycle.
// Stalls ID while EX is not ready or on load-use; optional counters under IDEX_PERF_CNT_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_OP_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_stage_if.slave bus
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0] perf_load_stalls,
    output logic [31:0] perf_flush_bubbles
`endif
);
    idex_state_e           state_q;
    logic                  ex_valid_q;
    logic [31:0]           ex_pc_q;
    logic [31:0]           ex_instr_q;
    logic [4:0]            ex_rs1_q;
    logic [4:0]            ex_rs2_q;
    logic [4:0]            ex_rd_q;
    id_ex_ctrl_t           ex_ctrl_q;
    id_ex_ctrl_t           id_ctrl;
    logic [DATA_WIDTH-1:0] ex_rs1_data_q;
    logic [DATA_WIDTH-1:0] ex_rs2_data_q;
    logic [DATA_WIDTH-1:0] ex_imm_q;
    logic [DATA_WIDTH-1:0] cap_a_q;
    logic [DATA_WIDTH-1:0] cap_b_q;
    logic [DATA_WIDTH-1:0] cap_st_q;
    logic [DATA_WIDTH-1:0] fwd_a_val;
    logic [DATA_WIDTH-1:0] fwd_b_val;
    logic [DATA_WIDTH-1:0] op_b_val;
    logic                  luh;
    logic                  load_bubble;
    logic                  load_id;

    assign id_ctrl = '{
        reg_write:   bus.id_reg_write,
        mem_read:    bus.id_mem_read,
        mem_write:   bus.id_mem_write,
        alu_src_imm: bus.id_alu_src_imm,
        alu_op:      CTRL_ALU_OP_W'(bus.id_alu_op)
    };

    assign luh = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != 5'd0) && bus.id_valid &&
                 ((bus.id_uses_rs1 && (bus.id_rs1_addr == ex_rd_q)) ||
                  (bus.id_uses_rs2 && (bus.id_rs2_addr == ex_rd_q)));

    // Flush wins over everything; a load-use bubble only lands when EX actually advances.
    assign load_bubble = bus.flush || (bus.ex_ready && luh);
    assign load_id     = !bus.flush && bus.ex_ready && !luh;

    assign bus.id_stall = !rst && !bus.flush && (!bus.ex_ready || luh);

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
        .fwd      (bus.forward_a),
        .reg_data (ex_rs1_data_q),
        .mem_data (bus.mem_fwd_data),
        .wb_data  (bus.wb_fwd_data),
        .operand  (fwd_a_val)
    );

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
        .fwd      (bus.forward_b),
        .reg_data (ex_rs2_data_q),
        .mem_data (bus.mem_fwd_data),
        .wb_data  (bus.wb_fwd_data),
        .operand  (fwd_b_val)
    );

    assign op_b_val = ex_ctrl_q.alu_src_imm ? ex_imm_q : fwd_b_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_instr_q    <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_ctrl_q     <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            cap_a_q       <= '0;
            cap_b_q       <= '0;
            cap_st_q      <= '0;
        end else begin
            if (bus.flush || bus.ex_ready) begin
                state_q <= ST_RUN;
            end else if (state_q == ST_RUN) begin
                // MEM/WB may retire while EX is stuck, so freeze the operands seen now.
                state_q  <= ST_HOLD;
                cap_a_q  <= fwd_a_val;
                cap_b_q  <= op_b_val;
                cap_st_q <= fwd_b_val;
            end

            if (load_bubble) begin
                ex_valid_q <= 1'b0;
                ex_ctrl_q  <= '0;
                ex_rs1_q   <= '0;
                ex_rs2_q   <= '0;
                ex_rd_q    <= '0;
            end else if (load_id) begin
                ex_valid_q    <= bus.id_valid;
                ex_pc_q       <= bus.id_pc;
                ex_instr_q    <= bus.id_instr;
                ex_rs1_q      <= bus.id_rs1_addr;
                ex_rs2_q      <= bus.id_rs2_addr;
                ex_rd_q       <= bus.id_rd_addr;
                ex_ctrl_q     <= id_ctrl;
                ex_rs1_data_q <= bus.id_rs1_data;
                ex_rs2_data_q <= bus.id_rs2_data;
                ex_imm_q      <= bus.id_imm;
            end
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.ex_instr      = ex_instr_q;
    assign bus.ex_rs1_addr   = ex_rs1_q;
    assign bus.ex_rs2_addr   = ex_rs2_q;
    assign bus.ex_rd_addr    = ex_rd_q;
    assign bus.ex_reg_write  = ex_valid_q && ex_ctrl_q.reg_write;
    assign bus.ex_mem_read   = ex_valid_q && ex_ctrl_q.mem_read;
    assign bus.ex_mem_write  = ex_valid_q && ex_ctrl_q.mem_write;
    assign bus.ex_alu_op     = ALU_OP_W'(ex_ctrl_q.alu_op);
    assign bus.ex_op_a       = (state_q == ST_HOLD) ? cap_a_q  : fwd_a_val;
    assign bus.ex_op_b       = (state_q == ST_HOLD) ? cap_b_q  : op_b_val;
    assign bus.ex_store_data = (state_q == ST_HOLD) ? cap_st_q : fwd_b_val;

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_stalls   <= '0;
            perf_flush_bubbles <= '0;
        end else begin
            if (!bus.flush && bus.ex_ready && luh && (perf_load_stalls != '1)) begin
                perf_load_stalls <= perf_load_stalls + 32'd1;
            end
            if (bus.flush && (ex_valid_q || bus.id_valid) && (perf_flush_bubbles != '1)) begin
                perf_flush_bubbles <= perf_flush_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against an EX-slot reference model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_WIDTH(32), .ALU_OP_W(4)) bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_ls;
    logic [31:0] perf_fb;
    id_ex_stage #(.DATA_WIDTH(32), .ALU_OP_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .perf_load_stalls(perf_ls), .perf_flush_bubbles(perf_fb));
`else
    id_ex_stage #(.DATA_WIDTH(32), .ALU_OP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Reference model: the instruction sitting in EX, plus operands frozen while EX is stalled.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, instr;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, imm_sel;
        logic [3:0]  alu;
        logic [31:0] d1, d2, imm;
    } slot_t;

    slot_t       m;
    logic        m_frozen;
    logic [31:0] m_fa, m_fb, m_fs;

    function automatic logic [31:0] pick(input logic [1:0] c, input logic [31:0] r, input logic [31:0] mv, input logic [31:0] wv);
        if (c == 2'b10) return mv;
        if (c == 2'b01) return wv;
        return r;
    endfunction

    function automatic logic model_hazard();
        return m.valid && m.mr && (m.rd != 0) && bus.id_valid &&
               ((bus.id_uses_rs1 && bus.id_rs1_addr == m.rd) || (bus.id_uses_rs2 && bus.id_rs2_addr == m.rd));
    endfunction

    function automatic logic [31:0] exp_store();
        return m_frozen ? m_fs : pick(bus.forward_b, m.d2, bus.mem_fwd_data, bus.wb_fwd_data);
    endfunction

    function automatic logic [31:0] exp_a();
        return m_frozen ? m_fa : pick(bus.forward_a, m.d1, bus.mem_fwd_data, bus.wb_fwd_data);
    endfunction

    function automatic logic [31:0] exp_b();
        if (m_frozen) return m_fb;
        return m.imm_sel ? m.imm : pick(bus.forward_b, m.d2, bus.mem_fwd_data, bus.wb_fwd_data);
    endfunction

    function automatic logic exp_stall();
        return !rst && !bus.flush && (!bus.ex_ready || model_hazard());
    endfunction

    task automatic model_step();
        if (rst) begin
            m = '0;
            m_frozen = 1'b0;
        end else if (bus.flush || (bus.ex_ready && model_hazard())) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.imm_sel = 0; m.alu = 0;
            m.rs1 = 0; m.rs2 = 0; m.rd = 0;
            m_frozen = 1'b0;
        end else if (!bus.ex_ready) begin
            if (!m_frozen) begin
                m_fa = exp_a(); m_fb = exp_b(); m_fs = exp_store();
                m_frozen = 1'b1;
            end
        end else begin
            m_frozen = 1'b0;
            m = '{valid: bus.id_valid, pc: bus.id_pc, instr: bus.id_instr,
                  rs1: bus.id_rs1_addr, rs2: bus.id_rs2_addr, rd: bus.id_rd_addr,
                  rw: bus.id_reg_write, mr: bus.id_mem_read, mw: bus.id_mem_write,
                  imm_sel: bus.id_alu_src_imm, alu: bus.id_alu_op,
                  d1: bus.id_rs1_data, d2: bus.id_rs2_data, imm: bus.id_imm};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2, input logic mr);
        bus.id_valid = v;        bus.id_pc = pc;          bus.id_instr = pc ^ 32'h13;
        bus.id_rs1_addr = rs1;   bus.id_rs2_addr = rs2;   bus.id_rd_addr = rd;
        bus.id_uses_rs1 = u1;    bus.id_uses_rs2 = u2;
        bus.id_reg_write = 1'b1; bus.id_mem_read = mr;    bus.id_mem_write = 1'b0;
        bus.id_alu_src_imm = 1'b0; bus.id_alu_op = 4'h3;
        bus.id_rs1_data = pc + 1; bus.id_rs2_data = pc + 2; bus.id_imm = pc + 3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ex_ready = 1'b1; bus.flush = 1'b0; bus.forward_a = 2'b00; bus.forward_b = 2'b00;
        bus.mem_fwd_data = '0; bus.wb_fwd_data = '0;
        drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); end
        checks++; if (bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", bus.ex_reg_write); end
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.id_stall); end
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b want 1", bus.ex_valid); end
        checks++; if (bus.ex_pc !== 32'h100) begin errors++; $display("FAIL reset_first_pc: got %h want 00000100", bus.ex_pc); end
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        drive_id(1'b1, 32'h204, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL luh_stall: got %b want 1", bus.id_stall); end
        tick();
        @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL luh_bubble: got %b want 0", bus.ex_valid); end
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL luh_release: got %b want 0", bus.id_stall); end
        tick();
        @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h204) begin errors++; $display("FAIL luh_advance: got v=%b pc=%h want v=1 pc=00000204", bus.ex_valid, bus.ex_pc); end
        checks++; if (bus.ex_rd_addr !== 5'd6) begin errors++; $display("FAIL luh_rd: got %0d want 6", bus.ex_rd_addr); end
    endtask

    task automatic test_no_false_stall();
        drive_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        tick();
        drive_id(1'b1, 32'h404, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL nostall_x0: got %b want 0", bus.id_stall); end
        drive_id(1'b1, 32'h408, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        drive_id(1'b1, 32'h40c, 5'd2, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL nostall_unused_rs2: got %b want 0", bus.id_stall); end
        bus.id_uses_rs2 = 1'b1;
        #1;
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL stall_used_rs2: got %b want 1", bus.id_stall); end
        drive_id(1'b0, 32'h410, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_forward();
        drive_id(1'b1, 32'h500, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b0, 32'h504, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.forward_a = 2'b10; bus.mem_fwd_data = 32'hDEADBEEF;
        bus.forward_b = 2'b01; bus.wb_fwd_data = 32'h1234;
        @(negedge clk);
        checks++; if (bus.ex_op_a !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_a_mem: got %h want deadbeef", bus.ex_op_a); end
        checks++; if (bus.ex_op_b !== 32'h1234) begin errors++; $display("FAIL fwd_b_wb: got %h want 00001234", bus.ex_op_b); end
        checks++; if (bus.ex_store_data !== 32'h1234) begin errors++; $display("FAIL fwd_store_wb: got %h want 00001234", bus.ex_store_data); end
        bus.forward_a = 2'b11;
        #1;
        checks++; if (bus.ex_op_a !== 32'h501) begin errors++; $display("FAIL fwd_a_reserved: got %h want 00000501", bus.ex_op_a); end
        bus.forward_b = 2'b00;
        #1;
        checks++; if (bus.ex_store_data !== 32'h502) begin errors++; $display("FAIL fwd_b_rf: got %h want 00000502", bus.ex_store_data); end
        drive_id(1'b1, 32'h600, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0);
        bus.id_alu_src_imm = 1'b1;
        tick();
        drive_id(1'b0, 32'h604, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.forward_b = 2'b10; bus.mem_fwd_data = 32'hCAFE0000;
        @(negedge clk);
        checks++; if (bus.ex_op_b !== 32'h603) begin errors++; $display("FAIL imm_op_b: got %h want 00000603", bus.ex_op_b); end
        checks++; if (bus.ex_store_data !== 32'hCAFE0000) begin errors++; $display("FAIL imm_store: got %h want cafe0000", bus.ex_store_data); end
        bus.forward_a = 2'b00; bus.forward_b = 2'b00;
        tick();
    endtask

    task automatic test_hold();
        bus.forward_a = 2'b10; bus.mem_fwd_data = 32'hAA; bus.ex_ready = 1'b1;
        drive_id(1'b1, 32'h700, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 32'h704, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0);
        bus.ex_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL hold_stall_enter: got %b want 1", bus.id_stall); end
        tick();
        bus.mem_fwd_data = 32'hBB;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.ex_op_a !== 32'hAA) begin errors++; $display("FAIL hold_op_a[%0d]: got %h want 000000aa", i, bus.ex_op_a); end
            checks++; if (bus.id_stall !== 1'b1 || bus.ex_pc !== 32'h700) begin errors++; $display("FAIL hold_state[%0d]: got stall=%b pc=%h want 1/00000700", i, bus.id_stall, bus.ex_pc); end
            tick();
        end
        bus.ex_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.ex_op_a !== 32'hAA || bus.id_stall !== 1'b0) begin errors++; $display("FAIL hold_release: got op_a=%h stall=%b want 000000aa/0", bus.ex_op_a, bus.id_stall); end
        tick();
        @(negedge clk);
        checks++; if (bus.ex_pc !== 32'h704 || bus.ex_op_a !== 32'hBB) begin errors++; $display("FAIL hold_advance: got pc=%h op_a=%h want 00000704/000000bb", bus.ex_pc, bus.ex_op_a); end
        bus.forward_a = 2'b00;
    endtask

    task automatic test_flush();
        bus.forward_a = 2'b10; bus.mem_fwd_data = 32'h11;
        drive_id(1'b1, 32'h800, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        drive_id(1'b1, 32'h804, 5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        bus.ex_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b want 1", bus.id_stall); end
        tick();
        bus.flush = 1'b1;
        @(negedge clk);
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", bus.id_stall); end
        tick();
        bus.flush = 1'b0; bus.ex_ready = 1'b1; bus.mem_fwd_data = 32'h55;
        @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0) begin errors++; $display("FAIL flush_bubble: got v=%b mr=%b want 0/0", bus.ex_valid, bus.ex_mem_read); end
        checks++; if (bus.ex_op_a !== 32'h55) begin errors++; $display("FAIL flush_run_state: got %h want 00000055", bus.ex_op_a); end
        bus.forward_a = 2'b00;
        drive_id(1'b0, 32'h808, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_pc = $urandom; bus.id_instr = $urandom;
            bus.id_rs1_addr = 5'($urandom_range(0, 3)); bus.id_rs2_addr = 5'($urandom_range(0, 3));
            bus.id_rd_addr = 5'($urandom_range(0, 3));
            bus.id_uses_rs1 = 1'($urandom); bus.id_uses_rs2 = 1'($urandom);
            bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
            bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom);
            bus.id_mem_write = 1'($urandom); bus.id_alu_src_imm = 1'($urandom);
            bus.id_alu_op = 4'($urandom);
            bus.ex_ready = ($urandom_range(0, 9) < 7);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.forward_a = 2'($urandom); bus.forward_b = 2'($urandom);
            bus.mem_fwd_data = $urandom; bus.wb_fwd_data = $urandom;
            @(negedge clk);
            checks++; if (bus.id_stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, bus.id_stall, exp_stall()); end
            checks++; if (bus.ex_valid !== m.valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.ex_valid, m.valid); end
            checks++;
            if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== {m.valid & m.rw, m.valid & m.mr, m.valid & m.mw}) begin
                errors++; $display("FAIL rnd_ctrl[%0d]: got %b%b%b want %b%b%b", i, bus.ex_reg_write, bus.ex_mem_read,
                                   bus.ex_mem_write, m.valid & m.rw, m.valid & m.mr, m.valid & m.mw);
            end
            if (m.valid) begin
                checks++;
                if (bus.ex_pc !== m.pc || bus.ex_instr !== m.instr || bus.ex_alu_op !== m.alu) begin
                    errors++; $display("FAIL rnd_fields[%0d]: got pc=%h ins=%h op=%h want %h %h %h", i, bus.ex_pc, bus.ex_instr, bus.ex_alu_op, m.pc, m.instr, m.alu);
                end
                checks++;
                if ({bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr} !== {m.rs1, m.rs2, m.rd}) begin
                    errors++; $display("FAIL rnd_addrs[%0d]: got %0d %0d %0d want %0d %0d %0d", i, bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr, m.rs1, m.rs2, m.rd);
                end
                checks++; if (bus.ex_op_a !== exp_a()) begin errors++; $display("FAIL rnd_op_a[%0d]: got %h want %h", i, bus.ex_op_a, exp_a()); end
                checks++; if (bus.ex_op_b !== exp_b()) begin errors++; $display("FAIL rnd_op_b[%0d]: got %h want %h", i, bus.ex_op_b, exp_b()); end
                checks++; if (bus.ex_store_data !== exp_store()) begin errors++; $display("FAIL rnd_store[%0d]: got %h want %h", i, bus.ex_store_data, exp_store()); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_forward();
        test_hold();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
